// File: rtl/booth_pkg.sv
// Shared types and constants for the Booth multiplier controller.
// Radix selection is controlled by the BOOTH_RADIX4_EN macro (undefined: radix-2).
package booth_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } booth_state_t;

    typedef logic signed [2:0] booth_digit_t;

    localparam int DEFAULT_WORD_SIZE = 32;

`ifdef BOOTH_RADIX4_EN
    localparam int WIN_W      = 3;
    localparam int STEP_SHIFT = 2;
`else
    localparam int WIN_W      = 2;
    localparam int STEP_SHIFT = 1;
`endif

    function automatic int calc_iters(input int word_size);
        return word_size / STEP_SHIFT;
    endfunction

    localparam int ITERS = calc_iters(DEFAULT_WORD_SIZE);
    localparam int CNT_W = $clog2(ITERS);

endpackage

// File: rtl/booth_mul_ctrl_if.sv
// Start/busy/done handshake and operand/result bus between the ALU and the multiplier.
interface booth_mul_ctrl_if #(
    parameter int WORD_SIZE = 32
);
    logic                 start;
    logic [WORD_SIZE-1:0] x;
    logic [WORD_SIZE-1:0] y;
    logic                 busy;
    logic                 done;
    logic [WORD_SIZE-1:0] hi;
    logic [WORD_SIZE-1:0] lo;

    modport master (
        output start, x, y,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, x, y,
        output busy, done, hi, lo
    );
endinterface

// File: rtl/booth_recode.sv
// Combinational Booth recoder: maps the low window of Q to a signed digit.
// Radix-4 window {Q[1],Q[0],q_1} when BOOTH_RADIX4_EN is defined, else radix-2 {Q[0],q_1}.
module booth_recode
    import booth_pkg::*;
(
    input  logic [WIN_W-1:0] window,
    output booth_digit_t     digit
);

    always_comb begin
        digit = 3'b000;
`ifdef BOOTH_RADIX4_EN
        case (window)
            3'b001, 3'b010: digit = 3'b001;
            3'b011:         digit = 3'b010;
            3'b100:         digit = 3'b110;
            3'b101, 3'b110: digit = 3'b111;
            default:        digit = 3'b000;
        endcase
`else
        case (window)
            2'b01:   digit = 3'b001;
            2'b10:   digit = 3'b111;
            default: digit = 3'b000;
        endcase
`endif
    end

endmodule

// File: rtl/booth_mul_ctrl.sv
// Iterative signed Booth multiplier with start/busy/done sequencing and HI/LO result registers.
// BOOTH_RADIX4_EN selects radix-4 recoding (half the steps); products are identical either way.
module booth_mul_ctrl
    import booth_pkg::*;
#(
    parameter int WORD_SIZE = DEFAULT_WORD_SIZE
) (
    input  logic                  clk,
    input  logic                  clr,
    booth_mul_ctrl_if.slave       bus
);

    localparam int STEPS  = calc_iters(WORD_SIZE);
    localparam int STEP_W = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam int AW     = WORD_SIZE + 2;
    localparam int PW     = AW + WORD_SIZE + 1;

    booth_state_t          state;
    logic [STEP_W-1:0]     count;
    logic                  busy_r;
    logic                  done_r;
    logic [WORD_SIZE-1:0]  hi_r;
    logic [WORD_SIZE-1:0]  lo_r;

    logic signed [AW-1:0]  a_reg;
    logic [WORD_SIZE-1:0]  q_reg;
    logic                  q_1;
    logic [WORD_SIZE-1:0]  y_reg;

    booth_digit_t          digit;
    logic signed [AW-1:0]  y_ext;
    logic signed [AW-1:0]  mag;
    logic signed [AW-1:0]  addend;
    logic signed [AW-1:0]  sum;
    logic signed [PW-1:0]  shifted;
    logic signed [AW-1:0]  next_a;
    logic [WORD_SIZE-1:0]  next_q;
    logic                  next_q1;

    booth_recode u_recode (
        .window ({q_reg[WIN_W-2:0], q_1}),
        .digit  (digit)
    );

    // Two guard bits on A keep +/-2Y and the negated most-negative operand in range.
    always_comb begin
        y_ext   = {{2{y_reg[WORD_SIZE-1]}}, y_reg};
        mag     = '0;
        case (digit)
            3'b001, 3'b111: mag = y_ext;
            3'b010, 3'b110: mag = y_ext <<< 1;
            default:        mag = '0;
        endcase
        addend  = digit[2] ? -mag : mag;
        sum     = a_reg + addend;
        shifted = $signed({sum, q_reg, q_1}) >>> STEP_SHIFT;
        next_a  = shifted[PW-1 -: AW];
        next_q  = shifted[WORD_SIZE:1];
        next_q1 = shifted[0];
    end

    always_ff @(posedge clk) begin
        if (!clr) begin
            state  <= IDLE;
            count  <= '0;
            busy_r <= 1'b0;
            done_r <= 1'b0;
            hi_r   <= '0;
            lo_r   <= '0;
            a_reg  <= '0;
            q_reg  <= '0;
            q_1    <= 1'b0;
            y_reg  <= '0;
        end else begin
            done_r <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (bus.start) begin
                        y_reg  <= bus.y;
                        a_reg  <= '0;
                        q_reg  <= bus.x;
                        q_1    <= 1'b0;
                        count  <= '0;
                        busy_r <= 1'b1;
                        state  <= RUN;
                    end else begin
                        state  <= IDLE;
                    end
                end
                RUN: begin
                    a_reg <= next_a;
                    q_reg <= next_q;
                    q_1   <= next_q1;
                    count <= count + 1'b1;
                    // hi/lo are only touched here so the previous product stays readable during RUN.
                    if (count == STEP_W'(STEPS - 1)) begin
                        hi_r   <= next_a[WORD_SIZE-1:0];
                        lo_r   <= next_q;
                        busy_r <= 1'b0;
                        done_r <= 1'b1;
                        state  <= DONE;
                    end
                end
                default: begin
                    busy_r <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy = busy_r;
    assign bus.done = done_r;
    assign bus.hi   = hi_r;
    assign bus.lo   = lo_r;

endmodule

// File: tb/tb_booth_mul_ctrl.sv
// Self-checking bench for booth_mul_ctrl: directed corner cases plus random operands
// compared against a plain signed-multiply reference and a cycle-count timing model.
module tb_booth_mul_ctrl;

`ifdef BOOTH_RADIX4_EN
    localparam int ITERS = 16;
`else
    localparam int ITERS = 32;
`endif

    logic clk;
    logic clr;
    int   checkCount;
    int   errorCount;
    logic [63:0] prevResult;

    booth_mul_ctrl_if #(.WORD_SIZE(32)) bus ();

    booth_mul_ctrl #(.WORD_SIZE(32)) dut (
        .clk (clk),
        .clr (clr),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checkCount++;
        if (got !== exp) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [63:0] refProduct(input logic [31:0] xv, input logic [31:0] yv);
        longint p;
        p = longint'($signed(xv)) * longint'($signed(yv));
        return 64'(p);
    endfunction

    task automatic checkQuiet(input string tag);
        checkOutput({tag, "_busy"}, 64'(bus.busy), 64'd0);
        checkOutput({tag, "_done"}, 64'(bus.done), 64'd0);
        checkOutput({tag, "_hilo"}, {bus.hi, bus.lo}, prevResult);
    endtask

    // Called at a negedge; returns at the negedge of the done cycle.
    task automatic applyStimulus(input logic [31:0] xv, input logic [31:0] yv, input int midStart);
        logic [63:0] expected;
        expected  = refProduct(xv, yv);
        bus.start = 1'b1;
        bus.x     = xv;
        bus.y     = yv;
        for (int c = 1; c <= ITERS; c++) begin
            @(negedge clk);
            checkOutput("run_busy", 64'(bus.busy), 64'd1);
            checkOutput("run_done", 64'(bus.done), 64'd0);
            checkOutput("run_hilo_hold", {bus.hi, bus.lo}, prevResult);
            if (c == midStart) begin
                bus.start = 1'b1;
                bus.x     = 32'd9;
                bus.y     = 32'd9;
            end else begin
                bus.start = 1'b0;
                bus.x     = $urandom;
                bus.y     = $urandom;
            end
        end
        @(negedge clk);
        checkOutput("done_busy", 64'(bus.busy), 64'd0);
        checkOutput("done_pulse", 64'(bus.done), 64'd1);
        checkOutput("product", {bus.hi, bus.lo}, expected);
        prevResult = expected;
    endtask

    task automatic idleCycle();
        bus.start = 1'b0;
        @(negedge clk);
        checkQuiet("idle");
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [31:0] rx, ry;
        int mid;
        checkCount = 0;
        errorCount = 0;
        prevResult = '0;
        clr        = 1'b0;
        bus.start  = 1'b0;
        bus.x      = 32'hDEAD_BEEF;
        bus.y      = 32'h1234_5678;

        repeat (3) @(negedge clk);
        checkQuiet("reset");
        clr = 1'b1;
        @(negedge clk);
        checkQuiet("post_reset");

        applyStimulus(32'd6, 32'd5, 0);
        idleCycle();
        applyStimulus(32'hFFFF_FFF9, 32'd3, 0);
        idleCycle();
        applyStimulus(32'h8000_0000, 32'h8000_0000, 0);
        idleCycle();
        applyStimulus(32'h7FFF_FFFF, 32'h8000_0000, 0);
        idleCycle();

        applyStimulus(32'd2, 32'd3, 0);
        applyStimulus(32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        idleCycle();

        applyStimulus(32'd4, 32'd4, 7);
        idleCycle();

        // Reset on the 5th RUN cycle of 100x100 discards the multiply without a done pulse.
        bus.start = 1'b1;
        bus.x     = 32'd100;
        bus.y     = 32'd100;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            bus.start = 1'b0;
            checkOutput("pre_clr_busy", 64'(bus.busy), 64'd1);
        end
        clr = 1'b0;
        prevResult = '0;
        @(negedge clk);
        checkQuiet("mid_clr");
        clr = 1'b1;
        for (int c = 0; c < ITERS + 2; c++) begin
            @(negedge clk);
            checkQuiet("after_clr");
        end
        applyStimulus(32'd100, 32'd100, 0);
        idleCycle();

        for (int n = 0; n < 24; n++) begin
            rx = $urandom;
            ry = $urandom;
            case ($urandom_range(0, 5))
                0: rx = 32'h8000_0000;
                1: ry = 32'h8000_0000;
                2: rx = 32'h7FFF_FFFF;
                3: ry = 32'(int'($urandom_range(0, 15)) - 8);
                default: ;
            endcase
            mid = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, ITERS - 1)) : 0;
            applyStimulus(rx, ry, mid);
            if ($urandom_range(0, 1) == 1) idleCycle();
        end
        idleCycle();

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule

// File: doc/booth_mul_ctrl.md
# booth_mul_ctrl

Sequencing controller and iterative datapath for signed 32×32 Booth multiplication in the CPU's MUL path. It accepts operands on a start/busy/done handshake and runs a fixed number of Booth add/shift steps. It then writes the 64-bit product to HI/LO outputs for the register-file writeback stage. The ALU issues one multiply at a time, and the controller owns all operand, accumulator and step-count state.

## Interface
- WORD_SIZE, default 32: operand width; product width is 2*WORD_SIZE.
- clk  input  1  system clock, rising edge.
- clr  input  1  synchronous active-low reset.
- start  input  1  request; operands sampled on the edge where start=1 and busy=0.
- x  input  WORD_SIZE  multiplier, signed two's complement.
- y  input  WORD_SIZE  multiplicand, signed two's complement.
- busy  output  1  high while a multiply is in progress (state RUN).
- done  output  1  one-cycle pulse: hi/lo are valid and newly written.
- hi  output  WORD_SIZE  upper half of product.
- lo  output  WORD_SIZE  lower half of product.

## Operation
- States: IDLE, RUN, DONE. clr=0 at any edge forces IDLE, step count 0, busy=0, done=0, hi=0, lo=0, and clears internal registers. Any in-flight multiply is discarded.
- IDLE/DONE with start=1: capture y into the multiplicand register. Load product register {A=0, Q=x, q_1=0} and step count 0. Go to RUN.
- IDLE with start=0 → IDLE. DONE with start=0 → IDLE.
- RUN: one Booth step per cycle.
  - The recoded digit d from the low window of Q is in {0,±1} for radix-2 and {0,±1,±2} for radix-4.
  - Update A ← A + d*Y.
  - Arithmetic-shift {A,Q,q_1} right by 1 for radix-2 or by 2 for radix-4.
- A is WORD_SIZE+2 bits wide and sign-extended, so that ±2Y and −(−2^(WORD_SIZE−1)) never overflow.
- After the final step (count = ITERS−1), write {hi,lo} ← low 2*WORD_SIZE bits of {A,Q} and go to DONE.
- start while busy=1 is ignored. It is not queued, and operands are not re-sampled.
- hi/lo change only on the completion edge or on reset. The previous result stays readable throughout the next RUN.
- The result is the exact signed product for all inputs, including −2^31 × −2^31 = 2^62.

## Timing
- Let edge 0 be the accepting edge. busy=1 during cycles 1..ITERS.
- hi/lo are written and DONE is entered on edge ITERS. done=1 for exactly the one cycle after edge ITERS.
- Back-to-back: start=1 during the DONE cycle is accepted at edge ITERS+1. busy rises immediately, with no idle bubble, giving a throughput of ITERS+1 cycles per multiply.
- busy and done are registered, never both high, and driven directly from state.
- Reset taking effect mid-RUN: the next cycle is IDLE with all outputs 0. done is not pulsed.

## Configuration
- BOOTH_RADIX4_EN defined: radix-4 (modified Booth) recoding with a 3-bit window {Q[1],Q[0],q_1}. Shift is 2 per step, ITERS = WORD_SIZE/2 = 16, and WORD_SIZE must be even.
- BOOTH_RADIX4_EN undefined: radix-2 recoding with a 2-bit window {Q[0],q_1}. Shift is 1 per step and ITERS = WORD_SIZE = 32.
- Products are identical in both builds; only latency differs.

## Structure
- Package booth_pkg holds:
  - the state enum typedef (IDLE, RUN, DONE);
  - the Booth digit typedef (signed 3-bit);
  - the ITERS constant, derived from BOOTH_RADIX4_EN and WORD_SIZE;
  - the step-counter width constant, $clog2(ITERS).
- Sub-module booth_recode is purely combinational. It maps the Q window to digit d and handles both radices under the macro. The controller instantiates it once and forms d*Y by select/shift/negate.

## Test plan
- x=6, y=5, start one cycle → done at cycle ITERS+1 after accept, hi=0x00000000, lo=0x0000001E. busy high for exactly ITERS cycles.
- x=−7 (0xFFFFFFF9), y=3 → hi=0xFFFFFFFF, lo=0xFFFFFFEB.
- x=y=0x80000000 → hi=0x40000000, lo=0x00000000. x=0x7FFFFFFF, y=0x80000000 → hi=0xC0000000, lo=0x80000000.
- First op (2×3) then start held high in the DONE cycle with x=−1, y=−1 → second op accepted with no gap, second done gives hi=0, lo=1. The first result (lo=6) stays visible until the second completion edge.
- start pulsed mid-RUN with x=9, y=9 → ignored. The original product (4×4 → lo=0x10) completes unchanged.
- clr=0 on the 5th RUN cycle of 100×100 → next cycle busy=0, done=0, hi=lo=0, no done pulse. A new start after release yields lo=0x2710 at normal latency.
